// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel-enable divider, x/y raster counters,
// registered active-low syncs aligned with the x/y update edge.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP     = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP     = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             tick;

    assign tick = (div_cnt_q == DIV_MAX);

    always_comb begin
        div_cnt_d = div_cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        if (tick) begin
            div_cnt_d = '0;
            x_d       = (x_q == H_MAX) ? 10'd0 : x_q + 10'd1;
            if (x_q == H_MAX) begin
                y_d = (y_q == V_MAX) ? 10'd0 : y_q + 10'd1;
            end
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
        // syncs decoded from next-state so they change on the same edge as x/y
        hsync_d = !((x_d >= H_SYNC_BEG) && (x_d <= H_SYNC_END));
        vsync_d = !((y_d >= V_SYNC_BEG) && (y_d <= V_SYNC_END));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
        end
    end

    assign p_tick     = tick;
    assign x          = x_q;
    assign y          = y_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = (x_q < H_DISP) && (y_q < V_DISP);
    assign frame_tick = tick && (x_q == H_MAX) && (y_q == V_MAX);

endmodule
